// File: rtl/rgb_unpack_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rgb_unpack_pkg
//  Description : Shared definitions for the RGB565 FIFO unpacker: FSM state
//                encoding, RGB565 field offsets and the 565 -> 888 expansion.
//  Revision    : 1.0 - initial release
// ============================================================================
package rgb_unpack_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_VS  = 2'd0,
      ST_ACTIVE   = 2'd1,
      ST_ERR_WAIT = 2'd2
   } state_t;

   // RGB565 layout: {r5, g6, b5}
   localparam int R_LSB = 11;
   localparam int R_W   = 5;
   localparam int G_LSB = 5;
   localparam int G_W   = 6;
   localparam int B_LSB = 0;
   localparam int B_W   = 5;

   // Replicate the MSBs into the vacated LSBs so full-scale maps to 0xFF.
   function automatic logic [23:0] expand565(input logic [15:0] p);
      logic [4:0] r5;
      logic [5:0] g6;
      logic [4:0] b5;
      r5 = p[R_LSB +: R_W];
      g6 = p[G_LSB +: G_W];
      b5 = p[B_LSB +: B_W];
      return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
   endfunction

endpackage : rgb_unpack_pkg
`default_nettype wire

// File: rtl/rgb565_to_888.sv
`default_nettype none
// ============================================================================
//  Module      : rgb565_to_888
//  Description : Registered RGB565 -> RGB888 expansion of one pixel plus the
//                matching 1-cycle delay of the video timing signals, so colour
//                and timing leave aligned.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                pix_vld, pix      - pixel strobe and RGB565 pixel
//                vs/hs/de_in       - timing inputs
//                vs/hs/de_out      - timing delayed by one cycle
//                r/g/b_out         - expanded colour, 0 when pix_vld is low
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb565_to_888
   import rgb_unpack_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_vld,
   input  logic [15:0] pix,
   input  logic        vs_in,
   input  logic        hs_in,
   input  logic        de_in,
   output logic        vs_out,
   output logic        hs_out,
   output logic        de_out,
   output logic [7:0]  r_out,
   output logic [7:0]  g_out,
   output logic [7:0]  b_out
);

   logic [23:0] rgb;

   always_comb begin
      rgb = 24'd0;
      if (pix_vld)
         rgb = expand565(pix);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_out <= 1'b0;
         hs_out <= 1'b0;
         de_out <= 1'b0;
         r_out  <= 8'd0;
         g_out  <= 8'd0;
         b_out  <= 8'd0;
      end else begin
         vs_out <= vs_in;
         hs_out <= hs_in;
         de_out <= de_in;
         r_out  <= rgb[23:16];
         g_out  <= rgb[15:8];
         b_out  <= rgb[7:0];
      end
   end

endmodule : rgb565_to_888
`default_nettype wire

// File: rtl/rgb565_fifo_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : rgb565_fifo_unpacker
//  Description : Read-side consumer of the HDMI prefetch FIFO. Pops packed
//                RGB565 words through a show-ahead rd_vld/rd_en handshake,
//                emits one pixel per active video cycle as RGB888, and flags
//                FIFO underflow and line/word misalignment.
//  Ports       : clk, rst          - read/pixel clock, sync active-high reset
//                enable            - run; low stops popping and blanks pixels
//                rd_data, rd_vld   - FIFO head word and its valid
//                rd_en             - combinational pop of the head word
//                vs/hs/de_in       - timing generator inputs
//                vs/hs/de_out      - timing delayed one cycle
//                r/g/b_out         - RGB888 aligned with de_out
//                underflow         - sticky error flag
//                err_cnt           - saturating error event count
//                clr_status        - clears underflow and err_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb565_fifo_unpacker
   import rgb_unpack_pkg::*;
#(
   parameter int PIX_PER_WORD = 2,
   parameter int DATA_W       = 16 * PIX_PER_WORD,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_vld,
   output logic              rd_en,
   input  logic              vs_in,
   input  logic              hs_in,
   input  logic              de_in,
   output logic              vs_out,
   output logic              hs_out,
   output logic              de_out,
   output logic [7:0]        r_out,
   output logic [7:0]        g_out,
   output logic [7:0]        b_out,
   output logic              underflow,
   output logic [CNT_W-1:0]  err_cnt,
   input  logic              clr_status
);

   localparam int PH_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(PIX_PER_WORD - 1);

   generate
      if (!(PIX_PER_WORD == 1 || PIX_PER_WORD == 2 || PIX_PER_WORD == 4)
          || DATA_W != 16 * PIX_PER_WORD) begin : g_param_check
         $error("rgb565_fifo_unpacker: illegal PIX_PER_WORD/DATA_W");
      end
   endgenerate

   state_t            state;
   logic [PH_W-1:0]   phase;
   logic              vs_d;
   logic              de_d;

   logic              vs_rise;
   logic              running;
   logic              take;
   logic              uf_evt;
   logic              ma_evt;
   logic              err_evt;
   logic              last;
   logic [15:0]       pix;

   assign vs_rise = vs_in & ~vs_d;
   assign running = (state == ST_ACTIVE) & enable;
   assign take    = running & de_in & rd_vld;
   assign uf_evt  = running & de_in & ~rd_vld;
   // Line ended part-way through a word: the packing is out of step.
   assign ma_evt  = running & ~de_in & de_d & (phase != '0);
   assign err_evt = uf_evt | ma_evt;
   assign last    = (phase == PH_LAST);

   // Depends only on registered state/phase and de_in/rd_vld/enable, never
   // on anything fed back from the FIFO, so no combinational loop forms.
   assign rd_en   = take & last & ~rst;

   always_comb begin
      pix = rd_data[15:0];
      for (int i = 1; i < PIX_PER_WORD; i++) begin
         if (phase == PH_W'(i))
            pix = rd_data[i*16 +: 16];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_WAIT_VS;
         phase <= '0;
         vs_d  <= 1'b0;
         de_d  <= 1'b0;
      end else begin
         vs_d <= vs_in;
         de_d <= de_in;
         if (!enable) begin
            state <= ST_WAIT_VS;
            phase <= '0;
         end else begin
            case (state)
               ST_WAIT_VS, ST_ERR_WAIT: begin
                  if (vs_rise) begin
                     state <= ST_ACTIVE;
                     phase <= '0;
                  end
               end
               ST_ACTIVE: begin
                  if (take) begin
                     phase <= last ? '0 : phase + PH_W'(1);
                  end else if (uf_evt) begin
                     // Word stays at the FIFO head; the writer realigns on
                     // the next frame.
                     state <= ST_ERR_WAIT;
                  end else if (ma_evt) begin
                     state <= ST_ERR_WAIT;
                     phase <= '0;
                  end else if (vs_rise) begin
                     phase <= '0;
                  end
               end
               default: begin
                  state <= ST_WAIT_VS;
                  phase <= '0;
               end
            endcase
         end
      end
   end

   // A clear coinciding with an error keeps that error.
   always_ff @(posedge clk) begin
      if (rst) begin
         underflow <= 1'b0;
         err_cnt   <= '0;
      end else if (clr_status) begin
         underflow <= err_evt;
         err_cnt   <= err_evt ? CNT_W'(1) : '0;
      end else if (err_evt) begin
         underflow <= 1'b1;
         if (err_cnt != {CNT_W{1'b1}})
            err_cnt <= err_cnt + CNT_W'(1);
      end
   end

   rgb565_to_888 u_expand (
      .clk     (clk),
      .rst     (rst),
      .pix_vld (take),
      .pix     (pix),
      .vs_in   (vs_in),
      .hs_in   (hs_in),
      .de_in   (de_in),
      .vs_out  (vs_out),
      .hs_out  (hs_out),
      .de_out  (de_out),
      .r_out   (r_out),
      .g_out   (g_out),
      .b_out   (b_out)
   );

endmodule : rgb565_fifo_unpacker
`default_nettype wire

// File: doc/rgb565_fifo_unpacker.md
Name: rgb565_fifo_unpacker

Overview:
Read-side consumer of the prefetch async FIFO in the HDMI output path, running in the FIFO read clock domain. Pops packed RGB565 words from the FIFO through its show-ahead rd_vld/rd_en handshake. Unpacks one pixel per active video cycle, driven by the video timing generator's de/hs/vs. Expands each pixel to RGB888 and detects underflow and line misalignment.

Parameters:
PIX_PER_WORD, 2, pixels packed per FIFO word. Legal values are 1, 2 and 4.
DATA_W, 16*PIX_PER_WORD, FIFO read data width. Must equal 16*PIX_PER_WORD.
CNT_W, 16, width of the saturating error counter.

Ports:
clk  in  1  pixel/read clock, the same clock as the FIFO rd_clk
rst  in  1  synchronous, active-high reset
enable  in  1  1 = run; 0 = stop popping and blank pixel data
rd_data  in  DATA_W  FIFO head word; pixel 0 is in bits [15:0]
rd_vld  in  1  FIFO head word valid (show-ahead)
rd_en  out  1  pop the FIFO head word; combinational
vs_in  in  1  vertical sync from the timing generator, active-high
hs_in  in  1  horizontal sync, active-high
de_in  in  1  active video
vs_out  out  1  vs_in delayed by 1 cycle
hs_out  out  1  hs_in delayed by 1 cycle
de_out  out  1  de_in delayed by 1 cycle
r_out  out  8  red
g_out  out  8  green
b_out  out  8  blue
underflow  out  1  sticky error flag
err_cnt  out  CNT_W  saturating count of error events
clr_status  in  1  clears underflow and err_cnt

Behaviour:
- Reset:
  - state=WAIT_VS, phase=0, vs_d=0.
  - All outputs are 0, including underflow and err_cnt.
  - rd_en=0.
- Frame start: vs_rise = vs_in & ~vs_d, with vs_d a 1-cycle register of vs_in.
- Timing pass-through:
  - vs/hs/de_out are registered copies of the inputs: 1-cycle latency in every state.
  - RGB is registered in the same cycle, so it is aligned with de_out.
- States:
  - WAIT_VS
    - rd_en=0; RGB=0.
    - Go to ACTIVE on vs_rise & enable, with phase=0.
  - ACTIVE
    - On de_in & rd_vld: output pixel[phase] of rd_data, then phase = (phase+1) mod PIX_PER_WORD.
    - rd_en = de_in & rd_vld & (phase==PIX_PER_WORD-1).
    - On de_in & ~rd_vld: underflow error. RGB=0, rd_en=0, go to ERR_WAIT.
    - On de_in falling edge (de_d & ~de_in) with phase!=0: misalign error. phase=0, go to ERR_WAIT. The partially used word is not popped.
    - On de_in=0: RGB=0.
  - ERR_WAIT
    - rd_en=0; RGB=0.
    - Go to ACTIVE with phase=0 on vs_rise & enable.
    - The FIFO is not flushed; the upstream writer realigns on frame.
- enable=0 in any state: go to WAIT_VS next cycle. rd_en is forced to 0 combinationally that same cycle.
- Pixel expansion from p[15:0] = {r5, g6, b5}:
  - R = {r5, r5[4:2]}
  - G = {g6, g6[5:4]}
  - B = {b5, b5[4:2]}
- Errors:
  - Each error event sets underflow=1 and increments err_cnt.
  - err_cnt saturates at all-ones.
  - clr_status clears both. If an error and clr_status occur in the same cycle, the result is underflow=1 and err_cnt=1.
  - An underflow cannot recur while in ERR_WAIT, so there is exactly one event per stall.
- vs_rise while in ACTIVE: resets phase to 0. It is not an error.
- Reset mid-frame: returns to WAIT_VS. The pixel after reset is black until the next vs_rise.
- rd_en depends only on registered state/phase and the inputs de_in, rd_vld and enable. There is no combinational loop through the FIFO.

Decomposition:
- Shared package rgb_unpack_pkg:
  - state encoding constants ST_WAIT_VS=0, ST_ACTIVE=1, ST_ERR_WAIT=2 (2-bit)
  - RGB565 field offsets
  - a function expand565 returning 24 bits
- One natural sub-module, rgb565_to_888: registered expansion of one pixel plus the timing-delay register.
- The FSM, phase counter and error counter stay in the top module.

Test Plan:
- Reset, then a vs pulse with enable=1, PIX_PER_WORD=2.
  - Stimulus: FIFO holds 0xF800_07E0 and de is high for 2 cycles.
  - Required: outputs (00,FF,00) then (FF,00,00), one cycle after de; rd_en pulses once, on the 2nd cycle.
- Pixel 0x8410 → R=0x84, G=0x82, B=0x84. Pixel 0x001F → (00,00,FF).
- Underflow:
  - Stimulus: rd_vld drops mid-line for 3 de cycles.
  - Required: black output, underflow=1, err_cnt=1 (not 3), rd_en stays 0 until the next vs_rise, then output resumes with phase 0.
- Misalignment: a line of 5 de cycles with PIX_PER_WORD=2 → err_cnt increments by 1, and the third word is not popped.
- Counters and clear:
  - Force 0x10000 errors with CNT_W=16 → err_cnt holds at 0xFFFF.
  - clr_status together with an error → underflow=1, err_cnt=1.
- Stop and reset mid-line:
  - enable=0 mid-line → rd_en=0 the same cycle, RGB=0 next cycle, state WAIT_VS.
  - rst mid-line → all outputs 0 the next cycle.
